vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, SHALL set the visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, SHALL set the horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, SHALL set the hsync pulse width in clocks.
REQ-004 Parameter H_BACK, default 48, SHALL set the horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, default 480, SHALL set the visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, SHALL set the vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, SHALL set the vsync pulse width in lines.
REQ-008 Parameter V_BACK, default 33, SHALL set the vertical back porch in lines.
REQ-009 Port vga_clk  input  1  SHALL be the pixel clock; all state SHALL update on its rising edge.
REQ-010 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-011 Port DrawX  output  10  SHALL be the current horizontal pixel position.
REQ-012 Port DrawY  output  10  SHALL be the current line position.
REQ-013 Port blank  output  1  SHALL be high only when the pixel is visible (display-enable polarity).
REQ-014 Port hs  output  1  SHALL be the active-low horizontal sync.
REQ-015 Port vs  output  1  SHALL be the active-low vertical sync.
REQ-016 Port frame_start  output  1  SHALL pulse high for one clock at position (0,0).
REQ-017 Port line_end  output  1  SHALL be high for one clock at DrawX = H_TOTAL-1 on every line.

Function
REQ-018 Constants: H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525).
REQ-019 DrawX SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-020 DrawY SHALL increment by 1 only on the clock where DrawX wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same clock.
REQ-021 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE, in the same cycle as that DrawX/DrawY.
REQ-022 hs SHALL be 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
REQ-023 vs SHALL be 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for full lines.
REQ-024 frame_start SHALL be 1 iff DrawX = 0 and DrawY = 0.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path to the ports. Decodes SHALL be computed from next-count values so that every output is cycle-aligned with DrawX/DrawY.
REQ-026 Counters SHALL be 10 bits; a parameter set with H_TOTAL or V_TOTAL > 1024 SHALL be rejected by an elaboration-time assertion.
REQ-027 Line period SHALL be exactly H_TOTAL clocks; frame period SHALL be exactly H_TOTAL*V_TOTAL clocks (default 420000).

Reset
REQ-028 While reset is high: DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, blank = 0, hs = 1, vs = 1, frame_start = 0, line_end = 1.
REQ-029 The first rising edge after reset deasserts SHALL produce DrawX = 0, DrawY = 0, blank = 1, and frame_start = 1.
REQ-030 Reset asserted mid-frame SHALL force the REQ-028 values immediately (asynchronously), independent of vga_clk.

Structure
REQ-031 Default timing constants and the H_TOTAL/V_TOTAL derivations SHALL live in a shared package, vga_timing_pkg, for reuse by sprite and renderer blocks.
REQ-032 One sub-module SHALL exist: vga_axis_counter (a wrap counter with a terminal-count output), instantiated once for the horizontal axis and once for the vertical axis, with the vertical instance enabled by the horizontal terminal count.

Verification
REQ-033 Release reset, then run 1 clock -> DrawX = 0, DrawY = 0, blank = 1, frame_start = 1; frame_start next high exactly 420000 clocks later.
REQ-034 Monitor one line -> hs low for exactly 96 consecutive clocks, starting at DrawX = 656; line_end high only at DrawX = 799.
REQ-035 Monitor one frame -> vs low for exactly 2×800 = 1600 clocks, starting at (DrawX 0, DrawY 490); blank high for exactly 307200 clocks.
REQ-036 Observe DrawX = 799, DrawY = 524 -> next clock gives DrawX = 0, DrawY = 0 (double wrap), frame_start = 1.
REQ-037 Assert reset at (DrawX 300, DrawY 200) between clock edges -> outputs equal the REQ-028 values before the next edge; after release, REQ-029 holds.
REQ-038 Instantiate with H_VISIBLE=320, H_FRONT=8, H_SYNC=48, H_BACK=24, V_* at defaults -> line period 400 clocks; hs low at DrawX 328..375.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : shared VGA timing defaults, axis-total helper, range decode
// Revision 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W         = 10;
  localparam int CNT_MAX_TOTAL = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // Half-open interval test [lo, hi) on a counter value.
  function automatic logic in_span(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : wrap counter 0..TOTAL-1 with terminal-count (wrap) output
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output cnt_t count,
  output cnt_t next_count,
  output logic wrap
);

  localparam cnt_t LAST = cnt_t'(TOTAL - 1);

  assign wrap = en && (count == LAST);

  always_comb begin
    next_count = count;
    if (wrap) begin
      next_count = '0;
    end else if (en) begin
      next_count = count + cnt_t'(1);
    end
  end

  // Reset parks on the last position so the first enabled edge lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LAST;
    end else begin
      count <= next_count;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : VGA raster counters with registered blank/sync/marker outputs
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  generate
    if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_err
      $error("vga_timing_gen: H_TOTAL %0d exceeds 10-bit counter range", H_TOTAL);
    end
    if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_err
      $error("vga_timing_gen: V_TOTAL %0d exceeds 10-bit counter range", V_TOTAL);
    end
  endgenerate

  cnt_t h_next;
  cnt_t v_next;
  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .clk        (vga_clk),
    .rst        (reset),
    .en         (1'b1),
    .count      (DrawX),
    .next_count (h_next),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .clk        (vga_clk),
    .rst        (reset),
    .en         (h_wrap),
    .count      (DrawY),
    .next_count (v_next),
    .wrap       (v_wrap)
  );

  // Decoding the next counts keeps every flopped output aligned with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      line_end    <= 1'b1;
    end else begin
      blank       <= in_span(h_next, 0, H_VISIBLE) && in_span(v_next, 0, V_VISIBLE);
      hs          <= !in_span(h_next, H_SYNC_START, H_SYNC_END);
      vs          <= !in_span(v_next, V_SYNC_START, V_SYNC_END);
      frame_start <= h_wrap && v_wrap;
      line_end    <= in_span(h_next, H_TOTAL - 1, H_TOTAL);
    end
  end

endmodule

`default_nettype wire
